pattern_seq_detector: RTL

PATTERN_SEQ_DETECTOR -- requirements
Module: pattern_seq_detector

---
 rtl/pattern_seq_detector.sv | 117 +++++++++++
 1 files changed

// File: rtl/pattern_seq_detector.sv
// rtl/pattern_seq_detector.sv - programmable symbol-sequence detector with saturating match counter
module pattern_seq_detector #(
    parameter int IN_W    = 3,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 8,
    parameter int OVERLAP = 1,
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int LEN_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_sym,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [IN_W-1:0]  cfg_sym,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             clr,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic [LEN_W-1:0] fill,
    output logic             cfg_err
);

    logic [IN_W-1:0]  r_pat  [DEPTH];
    logic [IN_W-1:0]  r_hist [DEPTH];
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_fill;
    logic [CNT_W-1:0] r_cnt;
    logic             r_match;
    logic             r_err;

    logic [IN_W-1:0]  w_hist_next [DEPTH];
    logic [LEN_W-1:0] w_fill_inc;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_accept;
    logic             w_hit;
    logic             w_idx_ok;
    logic             w_len_ok;

    assign w_accept   = in_valid & ~cfg_we & ~clr;
    assign w_fill_inc = (r_fill == LEN_W'(DEPTH)) ? r_fill : r_fill + LEN_W'(1);
    assign w_cnt_inc  = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_idx_ok   = int'(cfg_idx) < DEPTH;
    assign w_len_ok   = (cfg_len != '0) && (int'(cfg_len) <= DEPTH);

    always_comb begin
        w_hist_next[0] = in_sym;
        for (int i = 1; i < DEPTH; i++) begin
            w_hist_next[i] = r_hist[i-1];
        end
    end

    // History position i (0 = newest) pairs with pattern slot len-1-i, i.e. i + j + 1 == len.
    always_comb begin
        w_hit = (w_fill_inc >= r_len);
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (((i + j + 1) == int'(r_len)) && (w_hist_next[i] != r_pat[j])) begin
                    w_hit = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pat[i]  <= '0;
                r_hist[i] <= '0;
            end
            r_len   <= LEN_W'(DEPTH);
            r_fill  <= '0;
            r_cnt   <= '0;
            r_match <= 1'b0;
            r_err   <= 1'b0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_hist[i] <= '0;
            end
            r_fill  <= '0;
            r_cnt   <= '0;
            r_match <= 1'b0;
            r_err   <= 1'b0;
        end else if (cfg_we) begin
            if (w_idx_ok) begin
                r_pat[cfg_idx] <= cfg_sym;
            end
            if (w_len_ok) begin
                r_len <= cfg_len;
            end
            if (!w_idx_ok || !w_len_ok) begin
                r_err <= 1'b1;
            end
            r_fill  <= '0;
            r_match <= 1'b0;
        end else if (w_accept) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_hist[i] <= w_hist_next[i];
            end
            r_match <= w_hit;
            if (w_hit) begin
                r_cnt <= w_cnt_inc;
            end
            // Non-overlapping mode forgets everything seen once a match fires.
            r_fill <= (w_hit && (OVERLAP == 0)) ? '0 : w_fill_inc;
        end else begin
            r_match <= 1'b0;
        end
    end

    assign match     = r_match;
    assign match_cnt = r_cnt;
    assign fill      = r_fill;
    assign cfg_err   = r_err;

endmodule
